uart_rx_fifo: RTL

//  Parametrised UART receiver. Adds configurable frame format, majority-vote sampling,
//  a receive FIFO, per-byte error tags, overrun and break detection. Sits in the user

---
 rtl/uart_rx_fifo_pkg.sv | 11 +
 rtl/uart_rx_fifo_mem.sv | 41 ++++
 rtl/uart_rx_fifo.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: receiver FSM states and data-bit-count encodings
package uart_rx_fifo_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;
  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;
  function automatic logic [2:0] last_idx(input logic [1:0] dbits);
    return 3'd4 + 3'(dbits);
  endfunction
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: first-word-fall-through sync FIFO with level output
module uart_rx_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_rd, do_wr;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rp];
  // storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= do_wr ? wp + AW'(1) : wp;
      rp <= do_rd ? rp + AW'(1) : rp;
      level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with majority vote, error tags and receive FIFO
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CNT_W-1:0]              clk_div,
  input  logic [1:0]                    cfg_dbits,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_odd,
  input  logic                          cfg_stop2,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic                          break_det,
  input  logic                          err_clr,
  output logic                          irq,
  output logic                          busy
);
  logic [SYNC_STAGES-1:0] sync;
  logic rxs, rxs_d, fall, samp, wrap, maj, v0, v1, push, full, empty, brk;
  logic [CNT_W-1:0] cnt, div_q, h;
  logic [1:0] dbits_q;
  logic par_en_q, par_odd_q, stop2_q, perr, ferr, pbit;
  logic [7:0] sh;
  logic [2:0] bidx;
  state_t state, state_n;
  assign rxs = sync[SYNC_STAGES-1];
  assign fall = rxs_d && !rxs;
  assign h = div_q >> 1;
  assign samp = cnt == h + CNT_W'(1);
  assign wrap = cnt == div_q - CNT_W'(1);
  assign maj = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
  assign push = state == DONE;
  assign brk = state == STOP1 && samp && !maj && sh == '0 && !pbit;
  assign rd_valid = !empty;
  // input synchroniser, preset to idle-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      rxs_d <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      rxs_d <= rxs;
    end
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next state: stop bits end the frame at the decision point so back-to-back frames are not lost
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fall ? START : IDLE;
      START:   state_n = samp && maj ? IDLE : wrap ? DATA : START;
      DATA:    state_n = wrap && bidx == last_idx(dbits_q) ? (par_en_q ? PARITY : STOP1) : DATA;
      PARITY:  state_n = wrap ? STOP1 : PARITY;
      STOP1:   state_n = samp && !stop2_q ? DONE : wrap ? STOP2 : STOP1;
      STOP2:   state_n = samp ? DONE : STOP2;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // bit counter, vote samples, config capture and frame assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      div_q <= '0;
      dbits_q <= DBITS_8;
      par_en_q <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q <= 1'b0;
      v0 <= 1'b1;
      v1 <= 1'b1;
      sh <= '0;
      bidx <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      pbit <= 1'b0;
      busy <= 1'b0;
    end else begin
      cnt <= state == IDLE ? CNT_W'(fall) : wrap ? '0 : cnt + CNT_W'(1);
      v0 <= cnt == h - CNT_W'(1) ? rxs : v0;
      v1 <= cnt == h ? rxs : v1;
      busy <= state == START && samp && !maj ? 1'b1 : state_n == IDLE ? 1'b0 : busy;
      if (state == IDLE && fall) begin
        div_q <= clk_div;
        dbits_q <= cfg_dbits;
        par_en_q <= cfg_par_en;
        par_odd_q <= cfg_par_odd;
        stop2_q <= cfg_stop2;
        sh <= '0;
        bidx <= '0;
        perr <= 1'b0;
        ferr <= 1'b0;
        pbit <= 1'b0;
      end
      if (state == DATA && samp) sh[bidx] <= maj;
      if (state == DATA && wrap) bidx <= bidx + 3'd1;
      if (state == PARITY && samp) begin
        pbit <= maj;
        perr <= maj ^ (^sh) ^ par_odd_q;
      end
      if ((state == STOP1 || state == STOP2) && samp && !maj) ferr <= 1'b1;
    end
  end
  // sticky error flags (set beats clear) and registered interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
      break_det <= 1'b0;
      irq <= 1'b0;
    end else begin
      overrun <= push && full && !rd_en ? 1'b1 : err_clr ? 1'b0 : overrun;
      break_det <= brk ? 1'b1 : err_clr ? 1'b0 : break_det;
      irq <= rd_valid | overrun | break_det;
    end
  end
  uart_rx_fifo_mem #(.DEPTH(FIFO_DEPTH), .W(10)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(push),
    .wr_data({ferr, perr, sh}),
    .rd_en(rd_en),
    .rd_data({rd_ferr, rd_perr, rd_data}),
    .empty(empty),
    .full(full),
    .level(fifo_level)
  );
endmodule
